key_tone_gen: RTL and testbench

- Front-end of the Lab2 keyboard synthesiser. Consumes the raw 9-bit `key_input` (bits [8:7] = octave, bits [6:0] = one-hot note C..B).
- Synchronises and debounces the input, then decodes it into a half-period count and generates the square-wave tone.
- The tone feeds the downstream PWM/audio output stage. The status LEDs show what is being played.

---
 rtl/key_tone_pkg.sv | 24 ++
 rtl/key_debounce.sv | 62 ++++++
 rtl/key_tone_gen.sv | 135 +++++++++++++
 tb/tb_key_tone_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/key_tone_pkg.sv
// Shared widths, FSM states and the C4..B4 half-period table (100 MHz clock)
// for the keyboard tone front-end.
package key_tone_pkg;
   localparam int KEY_W = 9;
   localparam int HP_W  = 18;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_PLAY, ST_SUSTAIN} state_t;

   // Index 0 = C4 ... index 6 = B4
   localparam logic [6:0][HP_W-1:0] NOTE_HP = {
      18'd101239, 18'd113636, 18'd127551, 18'd143172,
      18'd151685, 18'd170265, 18'd191113
   };

   function automatic logic [HP_W-1:0] note_half_period(input logic [6:0] note,
                                                        input logic [1:0] octave);
      logic [HP_W-1:0] base;
      base = '0;
      for (int i = 0; i < 7; i++) begin
         if (note[i]) base = NOTE_HP[i];
      end
      return base >> octave;
   endfunction
endpackage

// File: rtl/key_debounce.sv
// 2-flop synchroniser plus stability counter; flags start/abort of settling and a
// one-cycle commit pulse once the synchronised value held STABLE_CYCLES cycles.
module key_debounce
   import key_tone_pkg::*;
#(
   parameter int W             = KEY_W,
   parameter int STABLE_CYCLES = 100000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] key_o,
   output logic         start_o,
   output logic         abort_o,
   output logic         commit_o
);
   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

   logic [W-1:0]  meta_q, sync_q, last_q, stable_q;
   logic [CW-1:0] cnt_q;
   logic          settling_q;
   logic          changed;

   assign changed  = (sync_q != stable_q);
   assign key_o    = sync_q;
   assign start_o  = !settling_q && changed;
   assign abort_o  = settling_q && !changed;
   assign commit_o = settling_q && changed && (sync_q == last_q) &&
                     (cnt_q == CW'(STABLE_CYCLES - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q     <= '0;
         sync_q     <= '0;
         last_q     <= '0;
         stable_q   <= '0;
         cnt_q      <= '0;
         settling_q <= 1'b0;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
         if (start_o) begin
            settling_q <= 1'b1;
            cnt_q      <= '0;
            last_q     <= sync_q;
         end else if (abort_o) begin
            settling_q <= 1'b0;
         end else if (commit_o) begin
            settling_q <= 1'b0;
            stable_q   <= sync_q;
         end else if (settling_q) begin
            // Any bounce restarts the stability window on the new value
            if (sync_q != last_q) begin
               last_q <= sync_q;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end
endmodule

// File: rtl/key_tone_gen.sv
// Debounced key decode and square-wave tone generator; new half_period 2+STABLE_CYCLES+1
// cycles after a key edge. Define TONE_SUSTAIN_EN to hold the tone after key release.
module key_tone_gen
   import key_tone_pkg::*;
#(
   parameter int STABLE_CYCLES  = 100000,
   parameter int SUSTAIN_CYCLES = 5000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [KEY_W-1:0] key_input,
   output logic            tone_out,
   output logic            tone_active,
   output logic [HP_W-1:0] half_period,
   output logic [4:0]      led
);
   localparam int SUS_W = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;

   logic [KEY_W-1:0] db_key;
   logic             db_start, db_abort, db_commit;

   state_t           state_q, ret_q;
   logic [HP_W-1:0]  hp_q, cnt_q;
   logic             tone_q, active_q, inv_q;
   logic [1:0]       oct_q;
   logic [SUS_W-1:0] sus_cnt_q;

   logic [6:0]       note;
   logic [HP_W-1:0]  note_hp;
   logic             note_valid, note_none, wrap, sus_live, sus_done, keep_sustain;

   key_debounce #(
      .W             (KEY_W),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_debounce (
      .clk_i    (clk),
      .rst_i    (rst),
      .raw_i    (key_input),
      .key_o    (db_key),
      .start_o  (db_start),
      .abort_o  (db_abort),
      .commit_o (db_commit)
   );

   always_comb begin
      note       = db_key[6:0];
      note_valid = ($countones(note) == 1);
      note_none  = (note == '0);
      note_hp    = note_half_period(note, db_key[8:7]);
      wrap       = (cnt_q == hp_q - HP_W'(1));
      // Sustain time keeps running while a new key is being debounced
      sus_live   = (state_q == ST_SUSTAIN) ||
                   ((state_q == ST_SETTLE) && (ret_q == ST_SUSTAIN));
      sus_done   = sus_live && (sus_cnt_q == SUS_W'(SUSTAIN_CYCLES - 1));
`ifdef TONE_SUSTAIN_EN
      keep_sustain = (ret_q == ST_PLAY) || ((ret_q == ST_SUSTAIN) && !sus_done);
`else
      keep_sustain = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ret_q     <= ST_IDLE;
         hp_q      <= '0;
         cnt_q     <= '0;
         tone_q    <= 1'b0;
         active_q  <= 1'b0;
         inv_q     <= 1'b0;
         oct_q     <= '0;
         sus_cnt_q <= '0;
      end else begin
         if (active_q) begin
            if (wrap) begin
               cnt_q  <= '0;
               tone_q <= ~tone_q;
            end else begin
               cnt_q <= cnt_q + HP_W'(1);
            end
         end
         if (sus_live && !sus_done) sus_cnt_q <= sus_cnt_q + SUS_W'(1);
         if (sus_done) begin
            hp_q     <= '0;
            cnt_q    <= '0;
            tone_q   <= 1'b0;
            active_q <= 1'b0;
         end

         case (state_q)
            ST_SETTLE: begin
               if (db_abort) begin
                  state_q <= sus_done ? ST_IDLE : ret_q;
               end else if (db_commit) begin
                  oct_q <= db_key[8:7];
                  if (note_valid) begin
                     hp_q     <= note_hp;
                     cnt_q    <= '0;
                     tone_q   <= 1'b0;
                     active_q <= 1'b1;
                     inv_q    <= 1'b0;
                     state_q  <= ST_PLAY;
                  end else if (note_none && keep_sustain) begin
                     inv_q   <= 1'b0;
                     state_q <= ST_SUSTAIN;
                     if (ret_q == ST_PLAY) sus_cnt_q <= '0;
                  end else begin
                     hp_q     <= '0;
                     cnt_q    <= '0;
                     tone_q   <= 1'b0;
                     active_q <= 1'b0;
                     inv_q    <= !note_none;
                     state_q  <= ST_IDLE;
                  end
               end else if (sus_done) begin
                  ret_q <= ST_IDLE;
               end
            end
            default: begin
               if (db_start) begin
                  state_q <= ST_SETTLE;
                  ret_q   <= sus_done ? ST_IDLE : state_q;
               end else if (sus_done) begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign tone_out    = tone_q;
   assign tone_active = active_q;
   assign half_period = hp_q;
   assign led         = {(state_q == ST_SETTLE), inv_q, oct_q, active_q};
endmodule

// File: tb/tb_key_tone_gen.sv
// Bench for key_tone_gen: run-length debounce model plus directed key sequences.
module tb_key_tone_gen;
   localparam int STABLE = 16;
   localparam int SUS    = 64;
`ifdef TONE_SUSTAIN_EN
   localparam bit SUSTAIN_ON = 1'b1;
`else
   localparam bit SUSTAIN_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [8:0]  key_input = '0;
   logic        tone_out, tone_active;
   logic [17:0] half_period;
   logic [4:0]  led;

   key_tone_gen #(.STABLE_CYCLES(STABLE), .SUSTAIN_CYCLES(SUS)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_input   (key_input),
      .tone_out    (tone_out),
      .tone_active (tone_active),
      .half_period (half_period),
      .led         (led)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int note_tab [7] = '{191113, 170265, 151685, 143172, 127551, 113636, 101239};

   // Model: ks is the input delayed two clocks; a value commits once it has been
   // seen for STABLE+1 consecutive cycles and differs from the committed key.
   logic [8:0] m_s1 = '0, m_ks = '0, m_prev = '0, m_run_val = '0, m_committed = '0;
   int         m_run_len = 0, m_edge = 0, m_t0 = 0, m_hp = 0, m_sus_end = 0, m_ones = 0;
   logic       m_active = 1'b0, m_inv = 1'b0, m_sus = 1'b0, m_led4 = 1'b0;
   logic [1:0] m_oct = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 = '0; m_ks = '0; m_run_val = '0; m_committed = '0;
         m_run_len = 0; m_edge = 0; m_t0 = 0; m_hp = 0; m_sus_end = 0;
         m_active = 1'b0; m_inv = 1'b0; m_sus = 1'b0; m_led4 = 1'b0; m_oct = '0;
      end else begin
         m_edge++;
         m_prev = m_ks;
         if (m_prev == m_run_val) m_run_len++;
         else begin
            m_run_val = m_prev;
            m_run_len = 1;
         end
         if (m_sus && m_edge == m_sus_end) begin
            m_sus = 1'b0; m_active = 1'b0; m_hp = 0;
         end
         if (m_run_len == STABLE + 1 && m_run_val != m_committed) begin
            m_committed = m_run_val;
            m_oct       = m_run_val[8:7];
            m_ones      = $countones(m_run_val[6:0]);
            if (m_ones == 1) begin
               m_hp = 0;
               for (int i = 0; i < 7; i++) if (m_run_val[i]) m_hp = note_tab[i] >> m_oct;
               m_active = 1'b1; m_t0 = m_edge; m_inv = 1'b0; m_sus = 1'b0;
            end else if (m_ones == 0 && m_active && SUSTAIN_ON) begin
               m_inv = 1'b0;
               if (!m_sus) begin
                  m_sus = 1'b1;
                  m_sus_end = m_edge + SUS;
               end
            end else begin
               m_active = 1'b0; m_hp = 0; m_sus = 1'b0; m_inv = (m_ones > 1);
            end
         end
         m_led4 = (m_prev != m_committed);
         m_ks   = m_s1;
         m_s1   = key_input;
      end
   end

   always @(negedge clk) begin
      int exp_tone;
      exp_tone = m_active ? (((m_edge - m_t0) / m_hp) % 2) : 0;
      chk("cyc_tone_out", tone_out, exp_tone);
      chk("cyc_tone_active", tone_active, m_active);
      chk("cyc_half_period", half_period, m_hp);
      chk("cyc_led", led, {m_led4, m_inv, m_oct, m_active});
   end

   initial begin
      // Reset held with C pressed
      rst = 1'b1; key_input = 9'h001;
      run(3);
      chk("rst_tone", tone_out, 0);
      chk("rst_active", tone_active, 0);
      chk("rst_hp", half_period, 0);
      chk("rst_led", led, 0);
      rst = 1'b0;
      run(18);
      chk("c_hp_before_commit", half_period, 0);
      chk("c_settling", led[4], 1);
      run(1);
      chk("c_hp", half_period, 191113);
      chk("c_led", led, 5'b00001);
      chk("c_model_hp", m_hp, 191113);

      // D, octave 1
      key_input = 9'h082;
      run(18);
      chk("d_hp_hold", half_period, 191113);
      run(1);
      chk("d_hp", half_period, 85132);
      chk("d_octave", led[2:1], 2'b01);
      chk("d_model_hp", m_hp, 85132);

      // Bounce on bit2, then hold E octave 2
      for (int i = 0; i < 20; i++) begin
         key_input = i[0] ? 9'h100 : 9'h104;
         run(5);
         chk("bounce_settling", led[4], 1);
         chk("bounce_hp_kept", half_period, 85132);
         chk("bounce_tone_live", tone_active, 1);
      end
      key_input = 9'h104;
      run(18);
      chk("e_hp_hold", half_period, 85132);
      run(1);
      chk("e_hp", half_period, 37921);
      chk("e_led", led, 5'b00101);

      // Chord then all-zero
      key_input = 9'h1C1;
      run(19);
      chk("chord_hp", half_period, 0);
      chk("chord_active", tone_active, 0);
      chk("chord_led", led, 5'b01110);
      key_input = 9'h000;
      run(19);
      chk("zero_led", led, 5'b00000);

      // A octave 0, reset mid-tone
      key_input = 9'h020;
      run(19);
      chk("a_hp", half_period, 113636);
      run(40);
      #2 rst = 1'b1;
      #1;
      chk("arst_tone", tone_out, 0);
      chk("arst_active", tone_active, 0);
      chk("arst_hp", half_period, 0);
      chk("arst_led", led, 0);
      run(3);
      rst = 1'b0;
      run(18);
      chk("a2_hp_before", half_period, 0);
      run(1);
      chk("a2_hp", half_period, 113636);
      chk("a2_tone_start", tone_out, 0);
      chk("a2_active", tone_active, 1);

      // B octave 3: first rise and fall of the tone
      key_input = 9'h1C0;
      run(19);
      chk("b_hp", half_period, 12654);
      chk("b_model_hp", m_hp, 12654);
      run(12653);
      chk("b_before_rise", tone_out, 0);
      run(1);
      chk("b_rise", tone_out, 1);
      run(12653);
      chk("b_before_fall", tone_out, 1);
      run(1);
      chk("b_fall", tone_out, 0);

      // A octave 3 then release
      key_input = 9'h1A0;
      run(19);
      chk("a3_hp", half_period, 14204);
      run(30);
      key_input = 9'h000;
      run(18);
      chk("rel_active_before", tone_active, 1);
      run(1);
      if (SUSTAIN_ON) begin
         chk("sus_active_commit", tone_active, 1);
         chk("sus_hp_commit", half_period, 14204);
         run(63);
         chk("sus_active_end", tone_active, 1);
         run(1);
         chk("sus_active_off", tone_active, 0);
         chk("sus_hp_off", half_period, 0);
      end else begin
         chk("rel_active_commit", tone_active, 0);
         chk("rel_hp_commit", half_period, 0);
         chk("rel_led_commit", led, 5'b00000);
      end
      run(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
